// File: rtl/user_uart_rx_if.sv
// rtl/user_uart_rx_if.sv - naive_bus register bus interface used by user_uart_rx
// Ports: rd_req/rd_gnt/rd_addr/rd_data read channel; wr_req/wr_gnt/wr_addr/wr_data/wr_be write channel.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/user_uart_rx.sv
// rtl/user_uart_rx.sv - 8N1 UART receiver with byte FIFO behind a naive_bus slave port
// Ports: clk system clock; rst_n async active-low reset; i_uart_rx async serial input (idle high);
//        bus naive_bus slave: 0x0 DATA (read pops {valid, byte}), 0x4 STATUS / write-1-to-clear errors.
module user_uart_rx #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_uart_rx,
    naive_bus.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0] FULL_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
    localparam int          DEPTH       = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

    // Input synchroniser plus one delayed copy for falling-edge detection.
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    logic rx_fall;
    assign rx_fall = rx_prev & ~rx_s2;

    // Receive FSM
    logic [1:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        cnt_zero;
    logic        stop_hit;
    logic        push;
    logic        ferr_set;

    assign cnt_zero = (bit_cnt == 16'd0);
    assign stop_hit = (state == ST_STOP) && cnt_zero;
    assign push     = stop_hit && rx_s2;
    assign ferr_set = stop_hit && !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        bit_cnt <= HALF_RELOAD;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_zero) begin
                        // Line back high at mid start bit means a glitch, not a frame.
                        if (!rx_s2) begin
                            bit_cnt <= FULL_RELOAD;
                            bit_idx <= 3'd0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        rx_shift[bit_idx] <= rx_s2;
                        bit_cnt           <= FULL_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Receive FIFO
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic               push_ok, pop, ovr_set;

    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = bus.rd_req && !bus.rd_addr[2] && !fifo_empty;
    assign push_ok    = push && !fifo_full;
    assign ovr_set    = push && fifo_full;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    logic ferr, ovr;
    logic wr_clr;

    assign wr_clr = bus.wr_req && bus.wr_addr[2] && bus.wr_be[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            ferr <= ferr_set | (ferr & ~(wr_clr & bus.wr_data[1]));
            ovr  <= ovr_set  | (ovr  & ~(wr_clr & bus.wr_data[0]));
        end
    end

    // Bus read path: zero-wait grant, data registered on the grant edge.
    logic [31:0] status_word, data_word, rd_data_q;
    logic [7:0]  count8;

    assign count8      = 8'(fifo_count);
    assign status_word = {16'd0, count8, 5'd0, ferr, ovr, fifo_empty};
    assign data_word   = fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_mem[rd_ptr]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 32'd0;
        end else if (bus.rd_req) begin
            rd_data_q <= bus.rd_addr[2] ? status_word : data_word;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_gnt  = bus.rd_req;
    assign bus.wr_gnt  = bus.wr_req;

    logic unused_bits;
    assign unused_bits = ^{bus.rd_addr[31:3], bus.rd_addr[1:0], bus.wr_addr[31:3],
                           bus.wr_addr[1:0], bus.wr_data[31:2], bus.wr_be[3:1]};

endmodule

// File: tb/tb_user_uart_rx.sv
// tb/tb_user_uart_rx.sv - self-checking bench for user_uart_rx
module tb_user_uart_rx;

    localparam int CLK_DIV = 64;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 16;
    localparam int HALF    = CLK_DIV / 2;
    localparam logic [31:0] DATA_A = 32'h0003_0010;
    localparam logic [31:0] STAT_A = 32'h0003_0014;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;

    naive_bus bus ();

    user_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (uart_rx),
        .bus       (bus.slave)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the receiver should hold, by the register rules only.
    logic [7:0] model_q [$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    function automatic logic [31:0] model_status();
        return {16'h0, 8'(model_q.size()), 5'b0, m_ferr, m_ovr, model_q.size() == 0};
    endfunction

    function automatic logic [31:0] model_pop();
        logic [7:0] b;
        if (model_q.size() == 0) return 32'h0;
        b = model_q.pop_front();
        return {23'h0, 1'b1, b};
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit)                 m_ferr = 1'b1;
        else if (model_q.size() == DEPTH) m_ovr = 1'b1;
        else                           model_q.push_back(b);
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_req  = 1'b0;
        data        = bus.rd_data;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.wr_be   = be;
        @(negedge clk);
        bus.wr_req  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        n_tests++;
        if (bus.rd_data !== 32'h0) begin
            $display("FAIL reset_rd_data: got %h expected %h", bus.rd_data, 32'h0); n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = STAT_A; bus.wr_req = 1'b1; bus.wr_addr = DATA_A; bus.wr_be = 4'h0;
        #1;
        n_tests++;
        if (bus.rd_gnt !== 1'b1 || bus.wr_gnt !== 1'b1) begin
            $display("FAIL grant_follows_req: got %b%b expected 11", bus.rd_gnt, bus.wr_gnt); n_fail++;
        end
        @(negedge clk);
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        got = bus.rd_data;
        n_tests++;
        if (got !== 32'h0000_0001) begin
            $display("FAIL reset_status: got %h expected %h", got, 32'h0000_0001); n_fail++;
        end
    endtask

    task automatic test_single();
        logic [31:0] got;
        send_frame(8'hA5, 1'b1, 8);
        model_frame(8'hA5, 1'b1);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status() || got !== 32'h0000_0100) begin
            $display("FAIL single_status: got %h expected %h", got, 32'h0000_0100); n_fail++;
        end
        bus_read(DATA_A, got);
        n_tests++;
        if (got !== model_pop()) begin
            $display("FAIL single_data: got %h expected %h", got, 32'h0000_01A5); n_fail++;
        end
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== 32'h0000_0001) begin
            $display("FAIL single_status_after: got %h expected %h", got, 32'h0000_0001); n_fail++;
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (bus.rd_data !== 32'h0000_0001) begin
            $display("FAIL rd_data_hold: got %h expected %h", bus.rd_data, 32'h0000_0001); n_fail++;
        end
    endtask

    task automatic test_glitch();
        logic [31:0] got;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat ($urandom_range(2, HALF - 8)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== 32'h0000_0001) begin
            $display("FAIL glitch_status: got %h expected %h", got, 32'h0000_0001); n_fail++;
        end
    endtask

    task automatic test_ferr();
        logic [31:0] got;
        send_frame(8'h3C, 1'b0, 8);
        model_frame(8'h3C, 1'b0);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status() || got !== 32'h0000_0005) begin
            $display("FAIL ferr_status: got %h expected %h", got, 32'h0000_0005); n_fail++;
        end
        bus_write(STAT_A, 32'h3, 4'h0);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== 32'h0000_0005) begin
            $display("FAIL ferr_clear_no_be: got %h expected %h", got, 32'h0000_0005); n_fail++;
        end
        bus_write(STAT_A, 32'h2, 4'h1);
        m_ferr = 1'b0;
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status()) begin
            $display("FAIL ferr_clear: got %h expected %h", got, model_status()); n_fail++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 4);
            model_frame(8'(i), 1'b1);
        end
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status() || got !== 32'h0000_1002) begin
            $display("FAIL ovr_status: got %h expected %h", got, 32'h0000_1002); n_fail++;
        end
        for (int i = 0; i <= DEPTH; i++) begin
            bus_read(DATA_A, got);
            exp = model_pop();
            n_tests++;
            if (got !== exp) begin
                $display("FAIL ovr_read_%0d: got %h expected %h", i, got, exp); n_fail++;
            end
        end
        bus_write(STAT_A, 32'h1, 4'h1);
        m_ovr = 1'b0;
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== 32'h0000_0001) begin
            $display("FAIL ovr_clear: got %h expected %h", got, 32'h0000_0001); n_fail++;
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] got;
        send_frame(8'h11, 1'b1, 8);
        model_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1, 8);
            begin
                // Aim the DATA read at the stop-bit sample edge of the second frame.
                @(negedge clk);
                repeat (HALF + 2 + 9 * CLK_DIV) @(posedge clk);
                bus_read(DATA_A, got);
            end
        join
        n_tests++;
        if (got !== model_pop()) begin
            $display("FAIL pushpop_data: got %h expected %h", got, 32'h0000_0111); n_fail++;
        end
        model_frame(8'h22, 1'b1);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status()) begin
            $display("FAIL pushpop_count: got %h expected %h", got, model_status()); n_fail++;
        end
        bus_read(DATA_A, got);
        n_tests++;
        if (got !== model_pop()) begin
            $display("FAIL pushpop_new: got %h expected %h", got, 32'h0000_0122); n_fail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        logic [7:0]  b;
        logic        sb;
        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            send_frame(b, sb, $urandom_range(1, CLK_DIV));
            model_frame(b, sb);
        end
        bus_write(DATA_A, $urandom, 4'hF);
        bus_read(STAT_A | 32'($urandom_range(0, 3)), got);
        exp = model_status();
        n_tests++;
        if (got !== exp) begin
            $display("FAIL rand_status: got %h expected %h", got, exp); n_fail++;
        end
        for (int i = 0; i < 9; i++) begin
            bus_read(DATA_A | 32'($urandom_range(0, 3)), got);
            exp = model_pop();
            n_tests++;
            if (got !== exp) begin
                $display("FAIL rand_data_%0d: got %h expected %h", i, got, exp); n_fail++;
            end
        end
        bus_write(STAT_A, 32'h3, 4'h1);
        m_ferr = 1'b0; m_ovr = 1'b0;
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== model_status()) begin
            $display("FAIL rand_clear: got %h expected %h", got, model_status()); n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got;
        logic [7:0]  b;
        b = 8'h55;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        model_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.rd_data !== 32'h0) begin
            $display("FAIL midreset_rd_data: got %h expected %h", bus.rd_data, 32'h0); n_fail++;
        end
        rst_n = 1'b1;
        repeat (12 * CLK_DIV) @(negedge clk);
        bus_read(STAT_A, got);
        n_tests++;
        if (got !== 32'h0000_0001) begin
            $display("FAIL midreset_status: got %h expected %h", got, 32'h0000_0001); n_fail++;
        end
        send_frame(8'h81, 1'b1, 8);
        model_frame(8'h81, 1'b1);
        bus_read(DATA_A, got);
        n_tests++;
        if (got !== model_pop()) begin
            $display("FAIL midreset_next: got %h expected %h", got, 32'h0000_0181); n_fail++;
        end
    endtask

    initial begin
        bus.rd_req  = 1'b0;
        bus.rd_addr = 32'h0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = 32'h0;
        bus.wr_data = 32'h0;
        bus.wr_be   = 4'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_ferr();
        test_overflow();
        test_push_pop();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/user_uart_rx.md
# user_uart_rx

Bus-slave UART receiver that completes the user serial port alongside the existing user UART transmitter. It oversamples the user RX pin, deframes 8N1 bytes into a receive FIFO, and exposes data and status to the core through a naive_bus slave port. In the SoC it is router slave 4, decoded at base 0x0003_0010 with mask 0x0000_0007 (two word registers).

## Interface
- CLK_DIV, default 434: clk cycles per UART bit (50 MHz / 115200); legal range 16..65535.
- FIFO_AW, default 4: FIFO address width; depth = 2**FIFO_AW bytes.
- clk  input  1  system clock, 50 MHz; the only clock.
- rst_n  input  1  asynchronous, active-low reset; all state clears immediately on assertion.
- i_uart_rx  input  1  asynchronous serial input, idles high.
- bus  naive_bus.slave  n/a  rd_req/rd_gnt/rd_addr[31:0]/rd_data[31:0], wr_req/wr_gnt/wr_addr[31:0]/wr_data[31:0]/wr_be[3:0].

## Operation
- Input sync: i_uart_rx passes two flip-flops (reset value 1) before any use.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: on synced falling edge (prev 1, now 0) load bit counter with CLK_DIV/2 - 1, go START.
- START: at counter zero sample line; 0 -> reload CLK_DIV-1, bit index 0, go DATA; 1 -> false start, back to IDLE, nothing pushed.
- DATA: each counter zero shift sample into bit[index], LSB first; after index 7 reload, go STOP.
- STOP: at counter zero sample; 1 -> push byte; 0 -> set sticky FERR, drop byte. Either way go IDLE (IDLE requires line high before next falling edge is accepted as a new edge).
- Push when FIFO full: byte dropped, sticky OVR set, FIFO contents untouched.
- Register 0x0 (DATA), read: {23'b0, valid, byte}. If FIFO non-empty: valid=1, byte=head, head popped. If empty: returns 0, no state change.
- Register 0x4 (STATUS), read: {16'b0, count[7:0], 5'b0, FERR, OVR, empty}; count zero-extended from FIFO_AW+1 bits. No side effects.
- Write 0x4: wr_be[0] and wr_data[1] -> clear FERR; wr_be[0] and wr_data[0] -> clear OVR. Writes to 0x0 are granted and ignored.
- Address decode uses rd_addr[2]/wr_addr[2] only; bits [1:0] ignored.
- Simultaneous push and pop in one cycle: both take effect, count unchanged; popped value is old head. Pop of the only entry with simultaneous push: returns old byte, new byte remains.
- Simultaneous set (new error) and software clear of the same flag: set wins.
- FIFO pointers wrap modulo depth; count saturates never (bounded by full check).

## Timing
- rd_gnt = rd_req, wr_gnt = wr_req, combinational, every cycle; no wait states.
- rd_data registered: valid the cycle after the grant cycle; holds until next granted read.
- Pop/state update happens on the grant clock edge; STATUS read in the next cycle reflects it.
- Byte visible (empty=0) on the clock edge after the stop-bit sample, i.e. ~9.5 bit times after start edge plus 3 cycles (2 sync + 1 push).
- Reset values: rd_data=0, FIFO empty, count=0, FERR=0, OVR=0, FSM IDLE, sync regs 1.
- rst_n asserted mid-frame: partial byte discarded; after release, receiver waits in IDLE for a fresh falling edge.

## Test plan
- Send 0xA5 at CLK_DIV=434 -> STATUS reads 0x0000_0100 (count 1); DATA read returns 0x0000_01A5; next STATUS 0x0000_0001.
- 200-cycle low glitch on idle line -> false start; STATUS stays 0x0000_0001, nothing pushed.
- Send 0x3C with stop bit driven 0 -> FERR set, STATUS 0x0000_0005; write 0x4 data 0x2 be 0x1 -> STATUS 0x0000_0001.
- Send 17 bytes 0x00..0x10 with FIFO_AW=4 -> count 16, OVR set (STATUS 0x0000_1002); 16 DATA reads return 0x100..0x10F, 0x10 absent; 17th read returns 0.
- Read DATA on the same cycle a byte is pushed into a 1-entry FIFO -> old byte returned, count stays 1.
- Assert rst_n low halfway through byte 0x55 -> after release STATUS 0x0000_0001, rd_data 0; next full byte 0x81 received correctly.
